// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one downstream AXI4 read channel (AR + R)
// among NUM_MASTERS upstream read masters. One burst is outstanding at a
// time. Termination follows the ARLEN-derived beat count, and a sticky
// error flags any RLAST that disagrees with that count.
module axi_read_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS*8-1:0]          m_arlen,
  output logic [NUM_MASTERS-1:0]            m_arready,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              m_rlast,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  output logic                              s_arvalid,
  output logic [ADDR_WIDTH-1:0]             s_araddr,
  output logic [7:0]                        s_arlen,
  input  logic                              s_arready,
  input  logic                              s_rvalid,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic                              s_rlast,
  output logic                              s_rready,
  output logic [$clog2(NUM_MASTERS)-1:0]    grant_id,
  output logic                              protocol_error
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [IW:0]   NM   = (IW+1)'(NUM_MASTERS);
  localparam logic [IW-1:0] LAST = IW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         grant_q;
  logic [7:0]            beat_count;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic                  err_q;

  logic                  found;
  logic [IW-1:0]         sel;
  logic [IW:0]           sum;
  logic                  beat;

  // Round-robin search: first requester at or above rr_ptr, modulo NUM_MASTERS.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise a path that skips it would infer a latch.
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= NM) sum = sum - NM;
      if (!found && m_arvalid[sum[IW-1:0]]) begin
        found = 1'b1;
        sel   = sum[IW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and channel steering; nothing is asserted in IDLE.
  always_comb begin
    state_d   = state_q;
    m_arready = '0;
    m_rvalid  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    beat      = 1'b0;
    case (state_q)
      IDLE: if (found) state_d = ADDR;
      ADDR: begin
        s_arvalid          = 1'b1;
        m_arready[grant_q] = s_arready;
        if (s_arready) state_d = DATA;
      end
      DATA: begin
        s_rready          = m_rready[grant_q];
        m_rvalid[grant_q] = s_rvalid;
        beat              = s_rvalid & m_rready[grant_q];
        if (beat && beat_count == 8'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, latched request, beat counter, pointer and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the latched address/length are ordinary flops, not a memory, so
    // they are reset like everything else and never expose stale values.
    if (!reset_n) begin
      rr_ptr     <= '0;
      grant_q    <= '0;
      beat_count <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (state_q == IDLE && found) begin
        grant_q    <= sel;
        addr_q     <= m_araddr[sel*ADDR_WIDTH +: ADDR_WIDTH];
        len_q      <= m_arlen[sel*8 +: 8];
        beat_count <= m_arlen[sel*8 +: 8];
      end
      if (beat) begin
        if (s_rlast != (beat_count == 8'd0)) err_q <= 1'b1;
        if (beat_count == 8'd0) rr_ptr <= (grant_q == LAST) ? '0 : grant_q + 1'b1;
        else                    beat_count <= beat_count - 8'd1;
      end
    end
  end

  assign s_araddr       = addr_q;
  assign s_arlen        = len_q;
  assign m_rdata        = s_rdata;
  assign m_rlast        = s_rlast;
  assign grant_id       = grant_q;
  assign protocol_error = err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: a table of arbitration vectors,
// hand-written corner sequences and randomized bursts against a
// transaction-level reference model.
module tb_axi_read_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              reset_n;
  logic [N-1:0]      m_arvalid;
  logic [N*AW-1:0]   m_araddr;
  logic [N*8-1:0]    m_arlen;
  logic [N-1:0]      m_arready;
  logic [N-1:0]      m_rvalid;
  logic [DW-1:0]     m_rdata;
  logic              m_rlast;
  logic [N-1:0]      m_rready;
  logic              s_arvalid;
  logic [AW-1:0]     s_araddr;
  logic [7:0]        s_arlen;
  logic              s_arready;
  logic              s_rvalid;
  logic [DW-1:0]     s_rdata;
  logic              s_rlast;
  logic              s_rready;
  logic [1:0]        grant_id;
  logic              protocol_error;

  axi_read_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_rready(m_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .s_rready(s_rready),
    .grant_id(grant_id), .protocol_error(protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: next-priority master and sticky error flag.
  int model_rr  = 0;
  bit model_err = 1'b0;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] len;
    int         grant;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester at or after the pointer, wrapping around.
  function automatic int model_pick(input logic [3:0] mask);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (model_rr + k) % N;
      if (mask[j[1:0]]) return j;
    end
    return 0;
  endfunction

  // One full burst. rv_mode: 0 = s_rvalid always, 1 = random.
  // rr_mode: 0 = always ready, 1 = toggle starting at 1, 2 = random.
  // bad_beat: beat index with a forced early s_rlast (-1 for none).
  // abort_at: return while still in DATA after this many beats (-1 for none).
  task automatic run_burst(input logic [3:0] mask, input int g, input logic [7:0] len,
                           input logic [31:0] addr, input int ar_delay, input int rv_mode,
                           input int rr_mode, input int bad_beat, input int abort_at);
    int acc;
    int cyc;
    int budget;
    logic [3:0] one_hot;
    one_hot = 4'b0001 << g;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      m_araddr[i*AW +: AW] = $urandom;
      m_arlen[i*8 +: 8]    = 8'($urandom_range(0, 255));
    end
    m_araddr[g*AW +: AW] = addr;
    m_arlen[g*8 +: 8]    = len;
    m_arvalid = mask;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    m_rready  = 4'hF;
    #1;
    check("idle_s_arvalid", s_arvalid, 0);
    check("idle_m_arready", m_arready, 0);
    check("idle_s_rready", s_rready, 0);
    check("idle_perr", protocol_error, model_err);
    for (int c = 0; c < ar_delay; c++) begin
      @(negedge clk); #1;
      check("addr_s_arvalid", s_arvalid, 1);
      check("addr_s_araddr", s_araddr, addr);
      check("addr_s_arlen", s_arlen, len);
      check("addr_wait_m_arready", m_arready, 0);
      check("addr_grant_id", grant_id, g);
    end
    @(negedge clk);
    s_arready = 1'b1;
    #1;
    check("hs_s_arvalid", s_arvalid, 1);
    check("hs_s_araddr", s_araddr, addr);
    check("hs_s_arlen", s_arlen, len);
    check("hs_m_arready", m_arready, one_hot);
    check("hs_grant_id", grant_id, g);
    @(negedge clk);
    m_arvalid = '0;
    s_arready = 1'b0;
    acc = 0;
    cyc = 0;
    budget = 20 * (int'(len) + 1) + 20;
    while (acc <= int'(len) && cyc < budget) begin
      check("data_perr", protocol_error, model_err);
      check("data_s_arvalid", s_arvalid, 0);
      if (abort_at >= 0 && acc == abort_at) return;
      s_rvalid = (rv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      case (rr_mode)
        0:       m_rready = 4'hF;
        1:       m_rready = (cyc % 2 == 0) ? 4'hF : 4'h0;
        default: m_rready = 4'($urandom_range(0, 15));
      endcase
      s_rdata = $urandom;
      s_rlast = (acc == int'(len)) || (acc == bad_beat);
      #1;
      check("data_s_rready", s_rready, m_rready[g]);
      check("data_m_rvalid", m_rvalid, s_rvalid ? one_hot : 4'h0);
      check("data_m_rdata", m_rdata, s_rdata);
      check("data_m_rlast", m_rlast, s_rlast);
      check("data_grant_id", grant_id, g);
      if (s_rvalid && m_rready[g]) begin
        if (s_rlast != (acc == int'(len))) model_err = 1'b1;
        acc++;
      end
      cyc++;
      @(negedge clk);
    end
    if (acc <= int'(len)) check("burst_timeout_beats", acc, int'(len) + 1);
    // Back in IDLE: further R traffic must not reach any master.
    s_rvalid = 1'b1;
    m_rready = 4'hF;
    s_rlast  = 1'b0;
    #1;
    check("end_s_rready", s_rready, 0);
    check("end_m_rvalid", m_rvalid, 0);
    check("end_perr", protocol_error, model_err);
    s_rvalid = 1'b0;
    model_rr = (g + 1) % N;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    // Arbitration vectors from reset (pointer starts at 0).
    tbl[0] = '{4'b1111, 8'd0, 0};
    tbl[1] = '{4'b1111, 8'd0, 1};
    tbl[2] = '{4'b1111, 8'd0, 2};
    tbl[3] = '{4'b1111, 8'd0, 3};
    tbl[4] = '{4'b1111, 8'd0, 0};
    tbl[5] = '{4'b1111, 8'd0, 1};
    tbl[6] = '{4'b0001, 8'd0, 0};
    tbl[7] = '{4'b1001, 8'd1, 3};
    tbl[8] = '{4'b0110, 8'd2, 1};
    tbl[9] = '{4'b0010, 8'd0, 1};

    reset_n   = 1'b0;
    m_arvalid = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_rready  = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rlast   = 1'b0;
    #1;
    check("rst_s_arvalid", s_arvalid, 0);
    check("rst_s_rready", s_rready, 0);
    check("rst_m_arready", m_arready, 0);
    check("rst_m_rvalid", m_rvalid, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_perr", protocol_error, 0);
    check("rst_s_araddr", s_araddr, 0);
    check("rst_s_arlen", s_arlen, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_burst(tbl[i].mask, tbl[i].grant, tbl[i].len, 32'h100 * (i + 1), i % 3, 0, 0, -1, -1);

    // Single master 1: addr 0x1000, arlen 3, AR ready after 2 cycles.
    run_burst(4'b0010, 1, 8'd3, 32'h0000_1000, 2, 0, 0, -1, -1);

    // Master 2 with toggling R ready over an arlen=1 burst.
    run_burst(4'b0100, 2, 8'd1, 32'h0000_2000, 0, 0, 1, -1, -1);

    // Randomized bursts against the model.
    for (int r = 0; r < 30; r++) begin
      logic [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      run_burst(mask, model_pick(mask), 8'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 3), 1, 2, -1, -1);
    end

    // Maximum length burst from master 3.
    run_burst(4'b1000, model_pick(4'b1000), 8'd255, 32'hDEAD_0000, 1, 1, 2, -1, -1);

    // Early RLAST on beat 2 of an arlen=3 burst; the error must stick.
    run_burst(4'b0001, model_pick(4'b0001), 8'd3, 32'h0000_3000, 0, 0, 0, 1, -1);
    check("err_set", protocol_error, 1);
    run_burst(4'b0100, model_pick(4'b0100), 8'd0, 32'h0000_4000, 1, 0, 0, -1, -1);
    check("err_sticky", protocol_error, 1);

    // Abandon a master-2 burst with beat_count=5 via asynchronous reset.
    run_burst(4'b0100, model_pick(4'b0100), 8'd7, 32'h0000_5000, 0, 0, 0, -1, 2);
    s_rvalid = 1'b1;
    m_rready = 4'hF;
    #1;
    check("pre_rst_m_rvalid", m_rvalid, 4'b0100);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_m_rvalid", m_rvalid, 0);
    check("async_s_rready", s_rready, 0);
    check("async_s_arvalid", s_arvalid, 0);
    check("async_m_arready", m_arready, 0);
    check("async_grant_id", grant_id, 0);
    check("async_perr", protocol_error, 0);
    s_rvalid  = 1'b0;
    model_rr  = 0;
    model_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_burst(4'b1001, 0, 8'd0, 32'h0000_6000, 0, 0, 0, -1, -1);
    run_burst(4'b1001, 3, 8'd2, 32'h0000_7000, 1, 1, 2, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Round-robin arbiter sharing one downstream AXI4 read channel (AR + R) among NUM_MASTERS upstream read masters.
- Sits between core/peripheral read masters and the memory-side slave port.
- Exactly one burst is outstanding at a time. Beats are counted from ARLEN, and a sticky error flags any RLAST mismatch.

Parameters:
- NUM_MASTERS, 4, number of upstream read masters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, read data width.

Ports:
- clk, input, 1, sole clock; all logic rises on posedge clk.
- reset_n, input, 1, asynchronous, active-low reset.
- m_arvalid, input, NUM_MASTERS, per-master AR valid.
- m_araddr, input, NUM_MASTERS*ADDR_WIDTH, per-master AR address; master i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_arlen, input, NUM_MASTERS*8, per-master AR length (beats minus 1).
- m_arready, output, NUM_MASTERS, per-master AR ready.
- m_rvalid, output, NUM_MASTERS, per-master R valid.
- m_rdata, output, DATA_WIDTH, read data broadcast to all masters.
- m_rlast, output, 1, last-beat indication broadcast to all masters.
- m_rready, input, NUM_MASTERS, per-master R ready.
- s_arvalid, output, 1, downstream AR valid.
- s_araddr, output, ADDR_WIDTH, downstream AR address.
- s_arlen, output, 8, downstream AR length.
- s_arready, input, 1, downstream AR ready.
- s_rvalid, input, 1, downstream R valid.
- s_rdata, input, DATA_WIDTH, downstream R data.
- s_rlast, input, 1, downstream R last.
- s_rready, output, 1, downstream R ready.
- grant_id, output, $clog2(NUM_MASTERS), index of the currently or last granted master.
- protocol_error, output, 1, sticky; set on an RLAST/count mismatch.

Behaviour:
- Reset (reset_n low, asynchronous) values:
  - state=IDLE; rr_ptr=0; grant_id=0; beat_count=0; protocol_error=0.
  - Latched address and length registers = 0.
  - Outputs: m_arready=0, m_rvalid=0, s_arvalid=0, s_rready=0.
- Reset asserted mid-burst abandons the burst with no cleanup; downstream must be reset together with this block.
- State IDLE:
  - Select the first i with m_arvalid[i], searching from rr_ptr upward modulo NUM_MASTERS.
  - On any request: latch that master's araddr/arlen into addr_q/len_q, set grant_id=i, set beat_count=arlen, go to ADDR.
  - No outputs are asserted in IDLE.
  - Grant decision to ADDR takes 1 cycle.
- State ADDR:
  - s_arvalid=1; s_araddr=addr_q; s_arlen=len_q.
  - m_arready[grant_id] = s_arready; all other bits 0.
  - On s_arready, go to DATA.
  - The upstream AR handshake completes in the same cycle as the downstream one. The master holds arvalid/addr stable until then, per AXI rules.
- State DATA:
  - s_rready = m_rready[grant_id].
  - m_rvalid[grant_id] = s_rvalid; other bits 0.
  - m_rdata = s_rdata; m_rlast = s_rlast (pure combinational pass-through, zero latency).
  - On each beat (s_rvalid && s_rready): beat_count decrements.
  - Beat with beat_count==0: go to IDLE and set rr_ptr = grant_id+1, wrapping to 0 after NUM_MASTERS-1.
- protocol_error is set (sticky until reset) when either:
  - a beat has s_rlast=1 while beat_count!=0, or
  - a beat has s_rlast=0 while beat_count==0.
- Burst termination always follows beat_count, never s_rlast.
- arlen=0 means a single-beat burst.
- Maximum burst is 256 beats; beat_count is 8 bits and never wraps inside a legal burst.
- Minimum back-to-back gap is one IDLE cycle between the final R beat and the next s_arvalid.
- Fairness: the granted master has lowest priority at the next arbitration. With N masters continuously requesting, each master waits at most N-1 bursts.
- A master dropping m_arvalid while in IDLE is legal. After grant (ADDR), withdrawing arvalid is a master protocol violation and is not checked.

Test Plan:
- Single master 1 requests araddr=0x1000, arlen=3; s_arready after 2 cycles; 4 R beats with s_rlast on the 4th -> s_araddr=0x1000, s_arlen=3, exactly 4 m_rvalid[1] beats, state back to IDLE, protocol_error=0.
- All 4 masters request continuously with arlen=0 -> grant order 0,1,2,3,0,1; rr_ptr wraps 3->0; m_rvalid asserted only on the granted bit each burst.
- Master 2 R backpressure: m_rready[2] toggles 1,0,1,0 during an arlen=1 burst -> s_rready mirrors it; data is accepted only on ready cycles; 2 beats completed.
- s_rlast asserted on beat 2 of an arlen=3 burst -> protocol_error goes to 1 and stays 1; burst still completes after 4 beats; next arbitration proceeds.
- reset_n pulsed low while in DATA with beat_count=5 -> all outputs drop to 0 asynchronously, rr_ptr=0; after release, master 0 wins when masters 0 and 3 both request.
- arlen=255 burst from master 3 -> exactly 256 beats accepted before IDLE; no premature termination; grant_id=3 throughout.
